median_window_ctrl: RTL

MEDIAN_WINDOW_CTRL -- requirements
Module: median_window_ctrl

---
 rtl/median_window_ctrl_pkg.sv | 15 +
 rtl/median_window_ctrl_edge_det.sv | 21 ++
 rtl/median_window_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/median_window_ctrl_pkg.sv
// Shared definitions for the 5x5 median window controller: FSM states and
// line/window geometry constants.
package median_pkg;

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      MEASURE    = 2'd1,
      RUN        = 2'd2
   } state_t;

   // Shortest line accepted as a frame's reference length.
   localparam int MIN_LINE = 8;
   localparam int WIN      = 5;

endpackage

// File: rtl/median_window_ctrl_edge_det.sv
// Registered rise/fall detector: compares the live input with its value
// from the previous clock.
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic r_prev;

   always_ff @(posedge clk) begin
      if (rst) r_prev <= 1'b0;
      else     r_prev <= i_sig;
   end

   assign o_rise = i_sig & ~r_prev;
   assign o_fall = ~i_sig & r_prev;

endmodule

// File: rtl/median_window_ctrl.sv
// Timing controller for a 5x5 median filter: measures the line length at
// frame start, tracks pixel position and flags when the window is populated.
module median_window_ctrl #(
   parameter int BRAM_SIZE_W = 13,
   parameter int Y_SIZE_W    = 12,
   parameter int WIN         = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   de_in,
   input  logic                   vsync_in,
   output logic                   line_ce,
   output logic [BRAM_SIZE_W-1:0] h_size,
   output logic [BRAM_SIZE_W-1:0] x_pos,
   output logic [Y_SIZE_W-1:0]    y_pos,
   output logic                   win_valid,
   output logic                   size_err,
   output median_pkg::state_t     dbg_state
);
   import median_pkg::*;

   localparam logic [BRAM_SIZE_W-1:0] LEN_MAX  = {BRAM_SIZE_W{1'b1}};
   localparam logic [BRAM_SIZE_W-1:0] LEN_ONE  = BRAM_SIZE_W'(1);
   localparam logic [BRAM_SIZE_W-1:0] LEN_MIN  = BRAM_SIZE_W'(MIN_LINE);
   localparam logic [BRAM_SIZE_W-1:0] X_FIRST  = BRAM_SIZE_W'(WIN - 1);
   localparam logic [Y_SIZE_W-1:0]    Y_MAX    = {Y_SIZE_W{1'b1}};
   localparam logic [Y_SIZE_W-1:0]    Y_ONE    = Y_SIZE_W'(1);
   localparam logic [Y_SIZE_W-1:0]    Y_FIRST  = Y_SIZE_W'(WIN - 1);

   state_t                 r_state;
   state_t                 w_state_next;
   logic [BRAM_SIZE_W-1:0] r_len;
   logic [BRAM_SIZE_W-1:0] r_h_size;
   logic [BRAM_SIZE_W-1:0] r_x_pos;
   logic [Y_SIZE_W-1:0]    r_y_pos;
   logic                   r_win_valid;
   logic                   r_size_err;
   logic                   r_line_ok;
   logic                   w_de_rise;
   logic                   w_de_fall;
   logic                   w_vs_rise;
   logic                   w_vs_fall_unused;
   logic                   w_pix;
   logic                   w_fall_ok;
   logic                   w_meas_sat;
   logic                   w_set_err;
   logic                   w_load_h;

   edge_det u_de_edge (
      .clk    (clk),
      .rst    (rst),
      .i_sig  (de_in),
      .o_rise (w_de_rise),
      .o_fall (w_de_fall)
   );

   // Only the start of vsync matters; its end carries no meaning here.
   edge_det u_vs_edge (
      .clk    (clk),
      .rst    (rst),
      .i_sig  (vsync_in),
      .o_rise (w_vs_rise),
      .o_fall (w_vs_fall_unused)
   );

   // A line counts only if its rising de edge was seen after frame start,
   // so a line cut by vsync (or by reset) is never measured or checked.
   assign w_pix      = de_in && (r_line_ok || w_de_rise) && (r_state != WAIT_FRAME);
   assign w_fall_ok  = w_de_fall && r_line_ok;
   assign w_meas_sat = (r_state == MEASURE) && w_pix && (r_len == LEN_MAX - LEN_ONE);

   always_ff @(posedge clk) begin
      if (rst) r_state <= WAIT_FRAME;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_set_err    = 1'b0;
      w_load_h     = 1'b0;
      if (w_vs_rise) begin
         w_state_next = MEASURE;
      end else begin
         case (r_state)
            MEASURE: begin
               if (w_meas_sat) begin
                  w_set_err    = 1'b1;
                  w_state_next = WAIT_FRAME;
               end else if (w_fall_ok) begin
                  w_load_h = 1'b1;
                  if (r_len < LEN_MIN) begin
                     w_set_err    = 1'b1;
                     w_state_next = WAIT_FRAME;
                  end else begin
                     w_state_next = RUN;
                  end
               end
            end
            RUN: begin
               if (w_fall_ok && (r_len != r_h_size)) w_set_err = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_len       <= '0;
         r_h_size    <= '0;
         r_x_pos     <= '0;
         r_y_pos     <= '0;
         r_size_err  <= 1'b0;
         r_line_ok   <= 1'b0;
         r_win_valid <= 1'b0;
      end else begin
         r_win_valid <= !w_vs_rise && w_pix && (r_state == RUN) &&
                        (r_x_pos >= X_FIRST) && (r_y_pos >= Y_FIRST) &&
                        !r_size_err && !w_set_err;
         if (w_vs_rise) begin
            r_len      <= '0;
            r_x_pos    <= '0;
            r_y_pos    <= '0;
            r_size_err <= 1'b0;
            r_line_ok  <= 1'b0;
         end else if (r_state == WAIT_FRAME) begin
            r_len     <= '0;
            r_x_pos   <= '0;
            r_y_pos   <= '0;
            r_line_ok <= 1'b0;
         end else begin
            if (w_set_err) r_size_err <= 1'b1;
            if (w_load_h)  r_h_size   <= r_len;
            if (w_de_rise)      r_line_ok <= 1'b1;
            else if (w_de_fall) r_line_ok <= 1'b0;
            if (w_pix) begin
               r_x_pos <= r_x_pos + LEN_ONE;
               if (r_len != LEN_MAX) r_len <= r_len + LEN_ONE;
            end else if (w_fall_ok) begin
               r_x_pos <= '0;
               r_len   <= '0;
               if (r_y_pos != Y_MAX) r_y_pos <= r_y_pos + Y_ONE;
            end
         end
      end
   end

   assign line_ce   = de_in && (r_state != WAIT_FRAME);
   assign h_size    = r_h_size;
   assign x_pos     = r_x_pos;
   assign y_pos     = r_y_pos;
   assign win_valid = r_win_valid;
   assign size_err  = r_size_err;
   assign dbg_state = r_state;

endmodule
